// File: rtl/mean_filter_sched.sv
// Round-robin scheduler that time-shares one mean_filter among NUM_CH sample sources.
// Define MEAN_FILTER_SCHED_STATS_EN to add saturating result/timeout counters (res_cnt_o, to_cnt_o).
module mean_filter_sched #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] req_data_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    output logic                     flt_en_o,
    output logic [DATA_W-1:0]        flt_data_o,
    input  logic [DATA_W-1:0]        flt_data_i,
    input  logic                     flt_done_i,
    output logic                     res_valid_o,
    output logic [DATA_W-1:0]        res_data_o,
    output logic [CH_W-1:0]          res_ch_o,
    input  logic                     res_ready_i,
    output logic                     busy_o,
    output logic                     timeout_o
`ifdef MEAN_FILTER_SCHED_STATS_EN
    ,
    output logic [15:0]              res_cnt_o,
    output logic [7:0]               to_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FEED = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [7:0]        burst_q, burst_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              flt_en_q, flt_en_d;
    logic [DATA_W-1:0] flt_data_q, flt_data_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              arb_found;
    logic [CH_W-1:0]   arb_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]     = req_data_i[gi*DATA_W +: DATA_W];
            assign req_ready_o[gi] = (state_q == S_FEED) && (gnt_q == CH_W'(gi));
        end
    endgenerate

    assign accept = |(req_valid_i & req_ready_o);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ready_o[i]) begin
                sel_data = sel_data | ch_data[i];
            end
        end
    end

    // First valid channel at or after the rotating pointer wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!arb_found && req_valid_i[(int'(rr_q) + i) % NUM_CH]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'((int'(rr_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        tmo_d       = tmo_q;
        flt_en_d    = 1'b0;
        flt_data_d  = flt_data_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    rr_d    = (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                    burst_d = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (accept) begin
                    flt_en_d   = 1'b1;
                    flt_data_d = sel_data;
                    if (burst_q == 8'(BURST_LEN - 1)) begin
                        burst_d = '0;
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        burst_d = burst_q + 8'd1;
                    end
                end
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still beats the timeout.
                if (flt_done_i) begin
                    res_data_d  = flt_data_i;
                    res_ch_d    = gnt_q;
                    res_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_RESP;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            tmo_q       <= '0;
            flt_en_q    <= 1'b0;
            flt_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            tmo_q       <= tmo_d;
            flt_en_q    <= flt_en_d;
            flt_data_q  <= flt_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign flt_en_o    = flt_en_q;
    assign flt_data_o  = flt_data_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_ch_o    = res_ch_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

`ifdef MEAN_FILTER_SCHED_STATS_EN
    logic [15:0] res_cnt_q, res_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;

    always_comb begin
        res_cnt_d = res_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (res_valid_q && res_ready_i && (res_cnt_q != 16'hFFFF)) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end
        if (timeout_q && (to_cnt_q != 8'hFF)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign res_cnt_o = res_cnt_q;
    assign to_cnt_o  = to_cnt_q;
`endif

endmodule

// File: tb/tb_mean_filter_sched.sv
// Randomized bench for mean_filter_sched with a behavioural mean-filter model and scoreboard.
module tb_mean_filter_sched;
    localparam int NUM_CH = 4, CH_W = 2, DATA_W = 8, BURST_LEN = 8, TIMEOUT = 64;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        req_valid_i = '0;
    logic [NUM_CH*DATA_W-1:0] req_data_i;
    logic [NUM_CH-1:0]        req_ready_o;
    logic                     flt_en_o;
    logic [DATA_W-1:0]        flt_data_o;
    logic [DATA_W-1:0]        flt_data_i;
    logic                     flt_done_i;
    logic                     res_valid_o;
    logic [DATA_W-1:0]        res_data_o;
    logic [CH_W-1:0]          res_ch_o;
    logic                     res_ready_i = 1'b0;
    logic                     busy_o;
    logic                     timeout_o;
`ifdef MEAN_FILTER_SCHED_STATS_EN
    logic [15:0]              res_cnt_o;
    logic [7:0]               to_cnt_o;
`endif

    always #5 clk = ~clk;

    mean_filter_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
                        .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .flt_en_o(flt_en_o), .flt_data_o(flt_data_o),
        .flt_data_i(flt_data_i), .flt_done_i(flt_done_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ch_o(res_ch_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o), .timeout_o(timeout_o)
`ifdef MEAN_FILTER_SCHED_STATS_EN
        , .res_cnt_o(res_cnt_o), .to_cnt_o(to_cnt_o)
`endif
    );

    int checks = 0;
    int failures = 0;
    int done_delay = 3;
    int exp_ptr = 0;

    // Each producer walks through its own table of samples, one entry per accept.
    logic [7:0] samp [NUM_CH][256];
    logic [7:0] sent_cnt [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_drv
            assign req_data_i[gi*DATA_W +: DATA_W] = samp[gi][sent_cnt[gi]];
        end
    endgenerate

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) sent_cnt[k] <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (req_valid_i[k] && req_ready_o[k]) sent_cnt[k] <= sent_cnt[k] + 8'd1;
        end
    end

    // Filter model: averages each group of BURST_LEN enabled samples, done done_delay cycles after the last.
    int fm_n, fm_sum, fm_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_n <= 0; fm_sum <= 0; fm_cnt <= 0;
            flt_done_i <= 1'b0; flt_data_i <= '0;
        end else begin
            flt_done_i <= 1'b0;
            if (flt_en_o && fm_n == BURST_LEN - 1) begin
                flt_data_i <= DATA_W'((fm_sum + int'(flt_data_o)) / BURST_LEN);
                fm_n <= 0; fm_sum <= 0;
                fm_cnt <= (done_delay == 1) ? 0 : 1;
                flt_done_i <= (done_delay == 1);
            end else begin
                if (flt_en_o) begin
                    fm_sum <= fm_sum + int'(flt_data_o);
                    fm_n <= fm_n + 1;
                end
                if (fm_cnt != 0) begin
                    flt_done_i <= (fm_cnt + 1 == done_delay);
                    fm_cnt <= (fm_cnt + 1 == done_delay || fm_cnt > 300) ? 0 : fm_cnt + 1;
                end
            end
        end
    end

    // Observation monitor, sampled on the falling edge.
    int cyc = 0, en_cnt = 0, lag_err = 0, ready_err = 0, ready_cycles = 0;
    int to_pulses = 0, to_cyc = 0, last_en_cyc = 0, rv_cycles = 0, burst_acc = 0;
    logic prev_acc = 1'b0;
    logic [7:0] prev_data = '0;
    logic [NUM_CH-1:0] prev_ready = '0;
    logic to_busy = 1'b0;
    int gnt_log[$], burst_log[$], res_ch_log[$], res_data_log[$];
    logic [NUM_CH-1:0] acc_v;
    assign acc_v = req_ready_o & req_valid_i;

    function automatic int oh_idx(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_acc <= 1'b0;
            prev_ready <= '0;
        end else begin
            prev_acc <= |acc_v;
            prev_data <= req_data_i[oh_idx(acc_v)*DATA_W +: DATA_W];
            if (flt_en_o !== prev_acc) lag_err <= lag_err + 1;
            else if (prev_acc && flt_data_o !== prev_data) lag_err <= lag_err + 1;
            if ($countones(req_ready_o) > 1) ready_err <= ready_err + 1;
            prev_ready <= req_ready_o;
            if (req_ready_o != 0) begin
                ready_cycles <= ready_cycles + 1;
                if (prev_ready == 0) begin
                    gnt_log.push_back(oh_idx(req_ready_o));
                    burst_acc <= int'(|acc_v);
                end else begin
                    burst_acc <= burst_acc + int'(|acc_v);
                end
            end else if (prev_ready != 0) begin
                burst_log.push_back(burst_acc);
            end
            if (flt_en_o) begin
                en_cnt <= en_cnt + 1;
                last_en_cyc <= cyc;
            end
            if (timeout_o) begin
                to_pulses <= to_pulses + 1;
                to_cyc <= cyc;
                to_busy <= busy_o;
                $display("timeout pulse cyc=%0d", cyc);
            end
            if (res_valid_o) rv_cycles <= rv_cycles + 1;
            if (res_valid_o && res_ready_i) begin
                res_ch_log.push_back(int'(res_ch_o));
                res_data_log.push_back(int'(res_data_o));
                $display("result ch=%0d data=%0d cyc=%0d", res_ch_o, res_data_o, cyc);
            end
        end
    end

    function automatic int rr_pick(input int ptr, input logic [NUM_CH-1:0] mask);
        for (int i = 0; i < NUM_CH; i++) if (mask[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
        return -1;
    endfunction

    function automatic int exp_mean(input int ch, input int start);
        int s = 0;
        for (int i = 0; i < BURST_LEN; i++) s += int'(samp[ch][(start + i) % 256]);
        return s / BURST_LEN;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = '0;
        step();
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic wait_results(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (res_ch_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({req_ready_o, flt_en_o, flt_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_feed got ready=%b en=%b data=%0d want 0", req_ready_o, flt_en_o, flt_data_o);
        end
        checks++;
        if ({res_valid_o, res_data_o, res_ch_o} !== '0) begin
            failures++;
            $display("FAIL reset_result got v=%b d=%0d ch=%0d want 0", res_valid_o, res_data_o, res_ch_o);
        end
        checks++;
        if ({busy_o, timeout_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status got busy=%b to=%b want 0", busy_o, timeout_o);
        end
`ifdef MEAN_FILTER_SCHED_STATS_EN
        checks++;
        if ({res_cnt_o, to_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_stats got res=%0d to=%0d want 0", res_cnt_o, to_cnt_o);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int eb, lb, rb, vb, tb0, gb, bb;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) samp[1][i] = 8'(i + 1);
        done_delay = 3;
        res_ready_i = 1'b1;
        eb = en_cnt; lb = lag_err; rb = res_ch_log.size(); vb = rv_cycles;
        tb0 = to_pulses; gb = gnt_log.size(); bb = burst_log.size();
        req_valid_i = 4'b0010;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (sent_cnt[1] >= 8) req_valid_i = '0;
            if (res_ch_log.size() > rb) begin ok = 1'b1; break; end
        end
        repeat (3) step();
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done got no result want 1 within 60 cycles"); end
        checks++;
        if (en_cnt - eb != 8) begin failures++; $display("FAIL single_en_count got %0d want 8", en_cnt - eb); end
        checks++;
        if (lag_err - lb != 0) begin failures++; $display("FAIL single_en_lag got %0d errors want 0", lag_err - lb); end
        checks++;
        if (rv_cycles - vb != 1) begin failures++; $display("FAIL single_valid_cycles got %0d want 1", rv_cycles - vb); end
        checks++;
        if (res_ch_log[rb] != 1) begin failures++; $display("FAIL single_ch got %0d want 1", res_ch_log[rb]); end
        checks++;
        if (res_data_log[rb] != exp_mean(1, 0)) begin
            failures++; $display("FAIL single_data got %0d want %0d", res_data_log[rb], exp_mean(1, 0));
        end
        checks++;
        if (to_pulses - tb0 != 0) begin failures++; $display("FAIL single_timeout got %0d pulses want 0", to_pulses - tb0); end
        checks++;
        if (gnt_log[gb] != 1 || burst_log[bb] != 8) begin
            failures++; $display("FAIL single_grant got ch=%0d n=%0d want ch=1 n=8", gnt_log[gb], burst_log[bb]);
        end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle got busy=%b want 0", busy_o); end
        exp_ptr = 2;
    endtask

    task automatic test_round_robin();
        int gb, bb, rb, rdy_b, ptr, g;
        int st [NUM_CH];
        bit ok;
        do_reset();
        done_delay = int'($urandom_range(1, 10));
        res_ready_i = 1'b1;
        for (int k = 0; k < NUM_CH; k++) st[k] = int'(sent_cnt[k]);
        gb = gnt_log.size(); bb = burst_log.size(); rb = res_ch_log.size(); rdy_b = ready_err;
        req_valid_i = 4'b1101;
        wait_results(rb + 4, 400, ok);
        req_valid_i = '0;
        step();
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_done got %0d results want 4", res_ch_log.size() - rb); end
        ptr = 0;
        for (int j = 0; j < 4; j++) begin
            g = rr_pick(ptr, 4'b1101);
            checks++;
            if (gnt_log[gb + j] != g || res_ch_log[rb + j] != g) begin
                failures++;
                $display("FAIL rr_order_%0d got gnt=%0d res_ch=%0d want %0d", j, gnt_log[gb + j], res_ch_log[rb + j], g);
            end
            checks++;
            if (burst_log[bb + j] != BURST_LEN || res_data_log[rb + j] != exp_mean(g, st[g])) begin
                failures++;
                $display("FAIL rr_burst_%0d got n=%0d data=%0d want n=8 data=%0d",
                         j, burst_log[bb + j], res_data_log[rb + j], exp_mean(g, st[g]));
            end
            st[g] += BURST_LEN;
            ptr = (g + 1) % NUM_CH;
        end
        checks++;
        if (ready_err != rdy_b) begin failures++; $display("FAIL rr_ready_onehot got %0d errors want 0", ready_err - rdy_b); end
        exp_ptr = ptr;
    endtask

    task automatic test_valid_gaps();
        int rcb, eb, lb, rb, st, fidx, g;
        bit ok;
        done_delay = 3;
        res_ready_i = 1'b1;
        st = int'(sent_cnt[0]);
        g = rr_pick(exp_ptr, 4'b0001);
        rcb = ready_cycles; eb = en_cnt; lb = lag_err; rb = res_ch_log.size();
        fidx = 0;
        req_valid_i = 4'b0001;
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (req_ready_o[0]) begin
                req_valid_i[0] = (fidx % 2 == 0);
                fidx++;
            end else if (fidx > 0) begin
                req_valid_i[0] = 1'b0;
            end
            if (res_ch_log.size() > rb) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL gaps_done got no result want 1 within 80 cycles"); end
        checks++;
        if (ready_cycles - rcb != 15) begin failures++; $display("FAIL gaps_feed_cycles got %0d want 15", ready_cycles - rcb); end
        checks++;
        if (en_cnt - eb != 8 || lag_err != lb) begin
            failures++; $display("FAIL gaps_en got count=%0d lag_errs=%0d want 8 and 0", en_cnt - eb, lag_err - lb);
        end
        checks++;
        if (res_ch_log[rb] != g || res_data_log[rb] != exp_mean(0, st)) begin
            failures++;
            $display("FAIL gaps_result got ch=%0d data=%0d want ch=%0d data=%0d", res_ch_log[rb], res_data_log[rb], g, exp_mean(0, st));
        end
        exp_ptr = 1;
    endtask

    task automatic test_back_pressure();
        int st, unstable, rb;
        logic [DATA_W-1:0] cap_d;
        logic [CH_W-1:0] cap_c;
        bit ok;
        done_delay = int'($urandom_range(1, 8));
        res_ready_i = 1'b0;
        st = int'(sent_cnt[1]);
        req_valid_i = 4'b0010;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (res_valid_o) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_valid got no res_valid want 1 within 100 cycles"); end
        cap_d = res_data_o;
        cap_c = res_ch_o;
        unstable = 0;
        repeat (10) begin
            step();
            if (res_valid_o !== 1'b1 || res_data_o !== cap_d || res_ch_o !== cap_c || req_ready_o !== '0) unstable++;
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
        checks++;
        if (cap_c != 1 || int'(cap_d) != exp_mean(1, st)) begin
            failures++; $display("FAIL bp_result got ch=%0d data=%0d want ch=1 data=%0d", cap_c, cap_d, exp_mean(1, st));
        end
        rb = res_ch_log.size();
        res_ready_i = 1'b1;
        step();
        checks++;
        if (res_valid_o !== 1'b0 || req_ready_o !== '0) begin
            failures++; $display("FAIL bp_release got valid=%b ready=%b want 0 and 0", res_valid_o, req_ready_o);
        end
        step();
        checks++;
        if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL bp_regrant got ready=%b want 0010", req_ready_o); end
        wait_results(rb + 2, 100, ok);
        req_valid_i = '0;
        step();
        checks++;
        if (!ok || res_ch_log[rb + 1] != 1 || res_data_log[rb + 1] != exp_mean(1, st + BURST_LEN)) begin
            failures++;
            $display("FAIL bp_second got ok=%0d ch=%0d data=%0d want ch=1 data=%0d",
                     ok, res_ch_log[rb + 1], res_data_log[rb + 1], exp_mean(1, st + BURST_LEN));
        end
        exp_ptr = 2;
    endtask

    task automatic test_timeout();
        int tb0, vb;
        do_reset();
        done_delay = 0;
        res_ready_i = 1'b1;
        tb0 = to_pulses; vb = rv_cycles;
        req_valid_i = 4'b0100;
        for (int n = 0; n < 150; n++) begin
            step();
            if (sent_cnt[2] >= 8) req_valid_i = '0;
            if (to_pulses > tb0) break;
        end
        repeat (5) step();
        checks++;
        if (to_pulses - tb0 != 1) begin failures++; $display("FAIL to_pulses got %0d want 1", to_pulses - tb0); end
        checks++;
        if (to_cyc - last_en_cyc != TIMEOUT) begin
            failures++; $display("FAIL to_latency got %0d want %0d", to_cyc - last_en_cyc, TIMEOUT);
        end
        checks++;
        if (rv_cycles != vb || to_busy !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL to_idle got res_valid_cycles=%0d busy_at_pulse=%b busy=%b want 0 0 0",
                                 rv_cycles - vb, to_busy, busy_o);
        end
`ifdef MEAN_FILTER_SCHED_STATS_EN
        checks++;
        if (to_cnt_o !== 8'd1 || res_cnt_o !== 16'd0) begin
            failures++; $display("FAIL to_stats got to=%0d res=%0d want 1 and 0", to_cnt_o, res_cnt_o);
        end
`endif
        exp_ptr = 3;
    endtask

    task automatic test_collision();
        int tb0, rb, g;
        bit ok;
        done_delay = 63;
        res_ready_i = 1'b1;
        tb0 = to_pulses; rb = res_ch_log.size();
        g = rr_pick(exp_ptr, 4'b0001);
        req_valid_i = 4'b0001;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (sent_cnt[0] >= 8) req_valid_i = '0;
            if (res_ch_log.size() > rb) begin ok = 1'b1; break; end
        end
        repeat (5) step();
        checks++;
        if (!ok || to_pulses != tb0) begin
            failures++; $display("FAIL collide got result=%0d timeouts=%0d want 1 and 0", ok, to_pulses - tb0);
        end
        checks++;
        if (res_ch_log[rb] != g || res_data_log[rb] != exp_mean(0, 0)) begin
            failures++;
            $display("FAIL collide_result got ch=%0d data=%0d want ch=%0d data=%0d", res_ch_log[rb], res_data_log[rb], g, exp_mean(0, 0));
        end
`ifdef MEAN_FILTER_SCHED_STATS_EN
        checks++;
        if (res_cnt_o !== 16'd1 || to_cnt_o !== 8'd1) begin
            failures++; $display("FAIL collide_stats got res=%0d to=%0d want 1 and 1", res_cnt_o, to_cnt_o);
        end
`endif
        exp_ptr = 1;
    endtask

    task automatic test_mid_reset();
        int st, gb, rb;
        bit ok;
        done_delay = 3;
        res_ready_i = 1'b1;
        st = int'(sent_cnt[3]);
        req_valid_i = 4'b1000;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (8'(sent_cnt[3] - 8'(st)) == 8'd4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || flt_en_o !== 1'b1) begin
            failures++; $display("FAIL midrst_setup got accepts_ok=%0d en=%b want 1 and 1", ok, flt_en_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, flt_en_o, flt_data_o, res_valid_o, res_data_o, res_ch_o, busy_o, timeout_o} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got ready=%b en=%b d=%0d v=%b rd=%0d ch=%0d busy=%b to=%b want all 0",
                     req_ready_o, flt_en_o, flt_data_o, res_valid_o, res_data_o, res_ch_o, busy_o, timeout_o);
        end
        step();
        rst_n = 1'b1;
        gb = gnt_log.size(); rb = res_ch_log.size();
        req_valid_i = 4'b1001;
        wait_results(rb + 1, 100, ok);
        req_valid_i = '0;
        step();
        checks++;
        if (gnt_log[gb] != rr_pick(0, 4'b1001)) begin
            failures++; $display("FAIL midrst_grant got %0d want %0d", gnt_log[gb], rr_pick(0, 4'b1001));
        end
        checks++;
        if (!ok || res_ch_log[rb] != 0 || res_ch_log.size() != rb + 1) begin
            failures++; $display("FAIL midrst_result got ok=%0d ch=%0d count=%0d want ch=0 count=1",
                                 ok, res_ch_log[rb], res_ch_log.size() - rb);
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++)
            for (int i = 0; i < 256; i++) samp[k][i] = 8'($urandom);
        test_reset();
        test_single();
        test_round_robin();
        test_valid_gaps();
        test_back_pressure();
        test_timeout();
        test_collision();
        test_mid_reset();
        checks++;
        if (lag_err != 0 || ready_err != 0) begin
            failures++; $display("FAIL global_monitor got lag_errs=%0d ready_errs=%0d want 0", lag_err, ready_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mean_filter_sched.md
Name: mean_filter_sched

Overview:
- Shares one mean_filter instance among NUM_CH sample sources.
- Uses a round-robin arbiter to grant one channel per burst of BURST_LEN samples.
- Feeds the granted samples into the filter, waits for the filter's done, then returns the result tagged with the channel index.
- Sits between the per-channel sample producers and the single filter datapath.

Parameters:
- NUM_CH, 4: number of requesting channels (2..4).
- CH_W, 2: channel index width; must satisfy 2**CH_W >= NUM_CH.
- DATA_W, 8: sample and result width; matches the filter's data_i/data_o.
- BURST_LEN, 8: samples fed to the filter per grant (1..255).
- TIMEOUT, 64: maximum cycles to wait for flt_done_i after the last sample (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_CH  per-channel sample valid.
- req_data_i  in  NUM_CH*DATA_W  per-channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_CH  per-channel sample accept; one-hot or zero.
- flt_en_o  out  1  filter enable, drives mean_filter en_i.
- flt_data_o  out  DATA_W  filter sample, drives mean_filter data_i.
- flt_data_i  in  DATA_W  filter result, from mean_filter data_o.
- flt_done_i  in  1  filter done, from mean_filter done_o.
- res_valid_o  out  1  result valid.
- res_data_o  out  DATA_W  captured filter result.
- res_ch_o  out  CH_W  channel that produced the result.
- res_ready_i  in  1  downstream accepts the result.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  one-cycle pulse when a burst is aborted by timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; all outputs 0; burst counter and timeout counter = 0.
  - RR pointer = 0, so channel 0 has highest priority first.
  - Reset mid-burst abandons the burst; no result is emitted.
- States: IDLE, FEED, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first valid channel searching from the RR pointer upward, modulo NUM_CH.
  - Register the grant; go to FEED next cycle.
  - RR pointer = (granted index + 1) mod NUM_CH.
- FEED:
  - req_ready_o[gnt] = 1 combinationally; all other ready bits are 0.
  - A sample is accepted when req_valid_i[gnt] & req_ready_o[gnt].
  - A sample accepted in cycle t appears on flt_data_o with flt_en_o=1 in cycle t+1 (registered, 1-cycle latency).
  - A cycle with no accept gives flt_en_o=0 next cycle; flt_data_o holds its last value.
  - The burst counter increments per accept.
  - On the BURST_LEN-th accept: go to WAIT, ready drops the following cycle, and exactly BURST_LEN samples are accepted.
  - flt_done_i is ignored in FEED.
- WAIT:
  - flt_en_o = 0 (the last sample's en pulse occurs in the first WAIT cycle); the timeout counter increments each cycle.
  - On flt_done_i: capture flt_data_i into res_data_o, set res_ch_o = gnt, res_valid_o = 1, go to RESP.
  - If the counter reaches TIMEOUT without done: pulse timeout_o for one cycle and go to IDLE; no result.
  - done and timeout in the same cycle: done wins.
- RESP:
  - res_valid_o, res_data_o and res_ch_o are held stable until res_ready_i.
  - On res_valid_o & res_ready_i: res_valid_o = 0 next cycle; go to IDLE.
  - No new grant until the result is consumed (back-pressure).
- Other rules:
  - busy_o = (state != IDLE), registered with the state.
  - Requests arriving while busy wait; there is no queuing beyond req_valid_i held by the requester.
  - A channel deasserting valid mid-burst keeps its grant; the scheduler waits indefinitely in FEED.

Optional Feature:
- Macro: MEAN_FILTER_SCHED_STATS_EN.
- Defined:
  - Adds outputs res_cnt_o [15:0] (results handed off, incremented on res_valid_o & res_ready_i) and to_cnt_o [7:0] (timeouts).
  - Both are saturating, reset to 0 by rst_n only.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then single channel:
  - Stimulus: rst_n low 1 cycle; ch1 valid with samples 1..8 back-to-back; filter model asserts done 3 cycles after the last en with data 8'd4; res_ready_i=1.
  - Required: flt_en_o high exactly 8 cycles, lagging accepts by 1; res_valid_o for 1 cycle with res_data_o=4, res_ch_o=1; timeout_o never asserted.
- Round-robin:
  - Stimulus: ch0, ch2 and ch3 all valid continuously.
  - Required: grant order 0,2,3,0; each grant accepts exactly 8 samples; res_ch_o sequence 0,2,3,0.
- Valid gaps:
  - Stimulus: ch0 valid toggling 1,0,1,0...
  - Required: flt_en_o follows the accepts with 1-cycle lag; the burst completes after 8 accepts (15 FEED cycles).
- Back-pressure:
  - Stimulus: res_ready_i=0 for 10 cycles after done, ch1 valid throughout.
  - Required: res_valid_o/data/ch stable for 10 cycles; no req_ready_o asserted until the result is consumed.
- Timeout:
  - Stimulus: filter model never asserts done; TIMEOUT=64.
  - Required: timeout_o pulses once, 64 cycles after entry to WAIT; state returns to IDLE; no res_valid_o. With the macro defined, to_cnt_o=1.
- Done/timeout collision and mid-burst reset:
  - Stimulus: done asserted in the 64th WAIT cycle.
  - Required: result emitted and no timeout_o.
  - Stimulus: rst_n low after 4 accepts.
  - Required: all outputs 0 immediately; the next grant goes to channel 0.
